ysyx_23060191_imem_resp: RTL and testbench
==========================================

# ysyx_23060191_imem_resp

Instruction-memory responder: the slave end of the fetch interface driven by the IFU. Accepts one word-aligned fetch request at a time over a valid/ready handshake, looks the word up in an internal memory array after a configurable latency, and returns data plus an error flag over a second valid/ready handshake. A simple load port lets the bench or loader preload the program.

## Interface
- ADDR_W, 32, request/load address width
- DATA_W, 32, instruction word width
- DEPTH, 1024, array depth in words
- BASE, 32'h8000_0000, byte address of word 0
- LATENCY, 2, cycles from request accept to first resp_valid; legal range 1..15
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_W  fetch byte address
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_data  out  DATA_W  fetched word (0 on error)
- resp_err  out  1  misaligned or out-of-range request
- ld_en  in  1  write one word into the array
- ld_addr  in  ADDR_W  load byte address
- ld_data  in  DATA_W  load word

## Operation
- FSM states: IDLE, WAIT, RESP. Reset -> IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_addr; LATENCY==1 -> RESP, else -> WAIT with cnt=LATENCY-1.
- WAIT: req_ready=0; cnt decrements each cycle; at cnt==1 -> RESP.
- On every entry to RESP: register resp_data/resp_err from latched address; resp_valid=1.
- RESP: req_ready=0; hold resp_valid, resp_data, resp_err stable until resp_ready; on resp_valid&&resp_ready -> IDLE.
- Error rules: resp_err=1 if addr[1:0]!=0, or addr<BASE, or addr>=BASE+4*DEPTH; resp_data=0 when resp_err=1. Otherwise index=(addr-BASE)>>2, width clog2(DEPTH); subtraction done in ADDR_W bits, no wrap into range.
- Load port: ld_en with aligned in-range ld_addr writes array[(ld_addr-BASE)>>2] at the edge; misaligned or out-of-range loads are silently dropped. Load is independent of FSM state.
- Read/write collision: data captured at the edge entering RESP sees array contents before a same-edge write (old value); writes on earlier edges, including during WAIT, are visible.
- Array contents are not reset; uninitialised words read as X in simulation only.

## Timing
- Reset values: state IDLE, cnt 0, resp_valid 0, resp_data 0, resp_err 0; req_ready forced 0 while rstn=0, 1 in the first cycle after release.
- Request accepted at edge E -> resp_valid first high in the cycle after edge E+LATENCY-1 (LATENCY=1: the cycle right after E).
- No pipelining: one outstanding request. Response handshake at edge F -> req_ready=1 in the cycle after F; minimum period between accepts is LATENCY+1 cycles with resp_ready tied 1.
- req_ready is a registered-state decode only (no combinational path from req_valid or resp_ready).
- req_addr is sampled only at the accept edge; later changes ignored.
- Reset mid-operation (WAIT or RESP): pending request discarded, no response issued, outputs return to reset values at that edge.

## Structure
- Shared defines file: CPU_WIDTH (DATA_W default), reset PC/BASE constant 32'h8000_0000, FSM state encoding (2-bit IDLE/WAIT/RESP).
- One sub-module: ysyx_23060191_imem_array, synchronous-write / asynchronous-read word array (DEPTH x DATA_W); the responder owns all handshake, latency and error logic.

## Test plan
- Reset then load 0x0010_0093 at 0x8000_0000, LATENCY=2, req 0x8000_0000 at accept edge E, resp_ready=1 -> resp_valid high exactly one cycle, cycle after E+1, resp_data=0x0010_0093, resp_err=0.
- Back-pressure: resp_ready=0 for 5 cycles -> resp_valid, resp_data stay constant, req_ready=0 throughout; raising resp_ready -> handshake, req_ready=1 next cycle.
- Errors: req 0x8000_0002 -> resp_err=1, data 0; req 0x7FFF_FFFC and 0x8000_1000 (DEPTH=1024) -> resp_err=1, data 0.
- Streaming with LATENCY=1, resp_ready=1, addresses 0x8000_0000..0x8000_000C -> four responses, accepts every 2 cycles, data matches preloaded words.
- Load collision: ld_en to 0x8000_0004 with 0xDEAD_BEEF on the edge entering RESP -> old value returned; refetch returns 0xDEAD_BEEF.
- rstn low while in WAIT -> no resp_valid ever for that request; after release req_ready=1, new request served normally.

Source files
------------

// File: rtl/ysyx_23060191_imem_resp_pkg.sv
// ysyx_23060191_imem_resp_pkg: shared widths, reset PC and responder FSM encoding
package ysyx_23060191_imem_resp_pkg;

    localparam int CPU_WIDTH = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_23060191_imem_array.sv
// ysyx_23060191_imem_array: word array with synchronous write and asynchronous read
module ysyx_23060191_imem_array
    import ysyx_23060191_imem_resp_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = CPU_WIDTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // contents are deliberately not reset; a program is loaded before use
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_23060191_imem_resp.sv
// ysyx_23060191_imem_resp: single-outstanding fetch responder with fixed latency and error flag
module ysyx_23060191_imem_resp
    import ysyx_23060191_imem_resp_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = CPU_WIDTH,
    parameter int                DEPTH   = 1024,
    parameter logic [ADDR_W-1:0] BASE    = RESET_PC,
    parameter int                LATENCY = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(4 * DEPTH);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              go_resp;
    logic [ADDR_W-1:0] lk_addr, lk_off, ld_off;
    logic              lk_hit, ld_hit;
    logic [DATA_W-1:0] rd_data;

    // with LATENCY==1 the lookup happens on the accept edge, before addr_q holds the address
    assign lk_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign lk_off  = lk_addr - BASE;
    assign lk_hit  = (lk_addr[1:0] == 2'b00) && (lk_addr >= BASE) && (lk_off < LIMIT);
    assign ld_off  = ld_addr - BASE;
    assign ld_hit  = (ld_addr[1:0] == 2'b00) && (ld_addr >= BASE) && (ld_off < LIMIT);

    ysyx_23060191_imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (ld_en && ld_hit),
        .waddr_i (ld_off[AW+1:2]),
        .wdata_i (ld_data),
        .raddr_i (lk_off[AW+1:2]),
        .rdata_o (rd_data)
    );

    // state and response registers; reset discards any pending request
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // next state: accept, count down the latency, then hold the response until taken
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d = req_addr;
                if (LATENCY == 1) go_resp = 1'b1;
                else begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                go_resp = (cnt_q == 4'd1);
            end
            RESP: if (resp_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            state_d = RESP;
            valid_d = 1'b1;
            err_d   = !lk_hit;
            data_d  = lk_hit ? rd_data : '0;
        end
    end

    assign req_ready  = rstn && (state_q == IDLE);
    assign resp_valid = valid_q;
    assign resp_data  = data_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060191_imem_resp.sv
// tb_ysyx_23060191_imem_resp: directed vectors against LATENCY=1 and LATENCY=2 responders
module tb_ysyx_23060191_imem_resp;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic [31:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_data [2];
    logic        resp_err [2];
    logic        ld_en;
    logic [31:0] ld_addr, ld_data;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_23060191_imem_resp #(.LATENCY(g + 1)) u_dut (
            .clk        (clk),
            .rstn       (rstn[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_data  (resp_data[g]),
            .resp_err   (resp_err[g]),
            .ld_en      (ld_en),
            .ld_addr    (ld_addr),
            .ld_data    (ld_data)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
    endtask

    task automatic fetch(input int d, input logic [31:0] a, output logic [31:0] data,
                         output logic err, output int lat);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        chk("accept_ready", 32'(req_ready[d]), 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = 32'h8000_0008;
        chk("busy_ready", 32'(req_ready[d]), 32'd0);
        lat = 0;
        while (resp_valid[d] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = resp_data[d];
        err  = resp_err[d];
    endtask

    task automatic fin(input int d);
        @(negedge clk);
        chk("drop_valid", 32'(resp_valid[d]), 32'd0);
        chk("ready_back", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        vec_t        tv [11];
        logic [31:0] words [4];
        logic [31:0] data;
        logic        err;
        int          lat;

        tv[0]  = '{32'h8000_0000, 1'b0, 32'h0010_0093};
        tv[1]  = '{32'h8000_0004, 1'b0, 32'h0020_0113};
        tv[2]  = '{32'h8000_0008, 1'b0, 32'h0030_0193};
        tv[3]  = '{32'h8000_000C, 1'b0, 32'h0040_0213};
        tv[4]  = '{32'h8000_0FFC, 1'b0, 32'hCAFE_F00D};
        tv[5]  = '{32'h8000_0002, 1'b1, 32'h0};
        tv[6]  = '{32'h8000_0001, 1'b1, 32'h0};
        tv[7]  = '{32'h7FFF_FFFC, 1'b1, 32'h0};
        tv[8]  = '{32'h8000_1000, 1'b1, 32'h0};
        tv[9]  = '{32'h0000_0000, 1'b1, 32'h0};
        tv[10] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
        for (int i = 0; i < 4; i++) words[i] = tv[i].data;

        rstn       = '{1'b0, 1'b0};
        req_valid  = '{1'b0, 1'b0};
        req_addr   = '{32'h0, 32'h0};
        resp_ready = '{1'b1, 1'b1};
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_data", resp_data[d], 32'h0);
            chk("rst_err", 32'(resp_err[d]), 32'd0);
        end
        rstn = '{1'b1, 1'b1};
        #1;
        for (int d = 0; d < 2; d++) chk("rel_ready", 32'(req_ready[d]), 32'd1);

        for (int i = 0; i < 5; i++) load(tv[i].addr, tv[i].data);
        load(32'h8000_0006, 32'hBAD0_0001);
        load(32'h8000_1000, 32'hBAD0_0002);
        load(32'h7FFF_FFFC, 32'hBAD0_0003);
        @(negedge clk);
        ld_en = 1'b0;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 11; i++) begin
                fetch(d, tv[i].addr, data, err, lat);
                chk("tv_latency", 32'(lat), 32'(d));
                chk("tv_data", data, tv[i].data);
                chk("tv_err", 32'(err), 32'(tv[i].err));
                fin(d);
            end
        end

        resp_ready[1] = 1'b0;
        fetch(1, 32'h8000_000C, data, err, lat);
        chk("bp_first", data, 32'h0040_0213);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid[1]), 32'd1);
            chk("bp_data", resp_data[1], 32'h0040_0213);
            chk("bp_ready", 32'(req_ready[1]), 32'd0);
        end
        resp_ready[1] = 1'b1;
        fin(1);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid[0] = 1'b1;
            req_addr[0]  = 32'h8000_0000 + 32'(4 * i);
            chk("stream_ready", 32'(req_ready[0]), 32'd1);
            @(negedge clk);
            chk("stream_valid", 32'(resp_valid[0]), 32'd1);
            chk("stream_data", resp_data[0], words[i]);
            chk("stream_busy", 32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0;
        fin(0);

        @(negedge clk);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0004;
        @(negedge clk);
        req_valid[1] = 1'b0;
        ld_en        = 1'b1;
        ld_addr      = 32'h8000_0004;
        ld_data      = 32'hDEAD_BEEF;
        chk("col_wait", 32'(resp_valid[1]), 32'd0);
        @(negedge clk);
        ld_en = 1'b0;
        chk("col_valid", 32'(resp_valid[1]), 32'd1);
        chk("col_old", resp_data[1], 32'h0020_0113);
        fin(1);
        fetch(1, 32'h8000_0004, data, err, lat);
        chk("col_new", data, 32'hDEAD_BEEF);
        fin(1);

        @(negedge clk);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0008;
        ld_en        = 1'b1;
        ld_addr      = 32'h8000_0008;
        ld_data      = 32'h1234_5678;
        @(negedge clk);
        req_valid[1] = 1'b0;
        ld_en        = 1'b0;
        @(negedge clk);
        chk("early_wr_valid", 32'(resp_valid[1]), 32'd1);
        chk("early_wr_data", resp_data[1], 32'h1234_5678);
        fin(1);

        @(negedge clk);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0FFC;
        @(negedge clk);
        req_valid[1] = 1'b0;
        rstn[1]      = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(resp_valid[1]), 32'd0);
        chk("mid_rst_ready", 32'(req_ready[1]), 32'd0);
        chk("mid_rst_data", resp_data[1], 32'h0);
        chk("mid_rst_err", 32'(resp_err[1]), 32'd0);
        @(negedge clk);
        rstn[1] = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(req_ready[1]), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("no_resp", 32'(resp_valid[1]), 32'd0);
        end
        fetch(1, 32'h8000_0000, data, err, lat);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_data", data, 32'h0010_0093);
        chk("post_rst_err", 32'(err), 32'd0);
        fin(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
